// File: rtl/rv_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e   : loader FSM states
//   HDR_BYTES : number of length-header bytes that precede the payload
package rv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader. Receives a byte stream made of a 16-bit
// little-endian word count followed by the payload. The payload is packed
// into little-endian 32-bit words, which are written to instruction memory
// at consecutive word addresses. The processor is held until the load
// completes.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-high reset
//   start      : one-cycle request to begin a load session
//   in_valid   : a byte is offered on in_data
//   in_data    : byte-stream payload
//   in_ready   : the loader accepts a byte this cycle
//   mem_we     : one-cycle word write strobe
//   mem_addr   : byte address of the written word (0 while mem_we=0)
//   mem_wdata  : word to write (0 while mem_we=0)
//   cpu_hold   : holds the processor while high
//   done       : load finished successfully
//   error      : header asked for more words than fit in MEM_BYTES
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_LO | waiting for word_count[7:0]
// LEN_HI | waiting for word_count[15:8]; range check on accept
// DATA   | assembling payload bytes and writing words
// DONE   | load complete, processor released
// ERR    | word count too large, processor stays held
module imem_loader
  import rv_loader_pkg::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int          WC_W      = 8 * HDR_BYTES;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [WC_W-1:0]   widx_q, widx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic              last_word;
  logic [WC_W-1:0]   total;
  logic [31:0]       bytes_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wc_q    <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    wdata_d = '0;

    in_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    accept    = in_valid && in_ready;
    total     = {in_data, wc_q[7:0]};
    bytes_req = 32'({total, 2'b00});
    // The write cycle of the final word ends the session; any byte offered
    // alongside it is surplus and dropped.
    last_word = we_q && (widx_q == wc_q - 1'b1);

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_LO;
          wc_d    = '0;
          widx_d  = '0;
          bcnt_d  = '0;
          asm_d   = '0;
        end
      end

      LEN_LO: begin
        if (accept) begin
          wc_d[7:0] = in_data;
          state_d   = LEN_HI;
        end
      end

      LEN_HI: begin
        if (accept) begin
          wc_d[15:8] = in_data;
          if (bytes_req > MEM_LIMIT) state_d = ERR;
          else if (total == '0)      state_d = DONE;
          else                       state_d = DATA;
        end
      end

      DATA: begin
        if (we_q) widx_d = widx_q + 1'b1;
        if (last_word) begin
          state_d = DONE;
        end else if (accept) begin
          bcnt_d = bcnt_q + 1'b1;
          case (bcnt_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              we_d    = 1'b1;
              wdata_d = {in_data, asm_q};
            end
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // widx_q still holds the index of the word being written during the
  // strobe cycle; it advances at the end of that cycle.
  assign mem_we    = we_q;
  assign mem_addr  = we_q ? ADDR_W'({widx_q, 2'b00}) : '0;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  bit mon_en   = 1'b0;

  imem_loader #(.MEM_BYTES(128), .ADDR_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
  endtask

  // Write counter plus idle-bus check, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we === 1'b1) wr_count++;
      else chk("idle_bus_zero", {mem_addr, mem_wdata}, 64'h0);
    end
  end

  logic [7:0] b1 [10];
  logic       vpat [7];
  logic [7:0] vbytes [4];

  initial begin
    int vi;
    b1     = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    vpat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vbytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 0);

    // Two words at full rate
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_len_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      send(b1[i]);
      if (i == 5) begin
        chk("t1_w0_we", mem_we, 1);
        chk("t1_w0_addr", mem_addr, 32'h0);
        chk("t1_w0_data", mem_wdata, 32'h0010_0013);
        chk("t1_w0_ready", in_ready, 1);
      end
      if (i == 6) chk("t1_we_single", mem_we, 0);
      if (i == 9) begin
        chk("t1_w1_we", mem_we, 1);
        chk("t1_w1_addr", mem_addr, 32'h4);
        chk("t1_w1_data", mem_wdata, 32'h0020_0093);
        chk("t1_w1_not_done", done, 0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("t1_done", done, 1);
    chk("t1_hold_rel", cpu_hold, 0);
    chk("t1_ready_off", in_ready, 0);
    chk("t1_wr_count", wr_count, 2);

    // Restart from DONE, empty load
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_done_clear", done, 0);
    chk("t2_hold", cpu_hold, 1);
    send(8'h00); send(8'h00);
    chk("t2_done", done, 1);
    in_valid = 1'b0;
    tick();
    chk("t2_wr_count", wr_count, 2);

    // 33 words do not fit in 128 bytes
    start = 1'b1; tick(); start = 1'b0;
    send(8'h21); send(8'h00);
    in_valid = 1'b0;
    chk("t3_error", error, 1);
    chk("t3_ready", in_ready, 0);
    chk("t3_hold", cpu_hold, 1);
    chk("t3_done", done, 0);
    tick(); tick();
    chk("t3_error_stays", error, 1);
    chk("t3_wr_count", wr_count, 2);

    // 32 words exactly fill memory: accepted
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_error_clear", error, 0);
    send(8'h20); send(8'h00);
    in_valid = 1'b0;
    chk("t4_no_error", error, 0);
    chk("t4_data_ready", in_ready, 1);

    // One word with gaps in in_valid
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    send(8'h01); send(8'h00);
    vi = 0;
    for (int k = 0; k < 7; k++) begin
      in_valid = vpat[k];
      in_data  = vpat[k] ? vbytes[vi] : 8'hFF;
      if (vpat[k]) vi++;
      tick();
      if (k < 6) chk("t5_no_early_we", mem_we, 0);
    end
    chk("t5_we", mem_we, 1);
    chk("t5_addr", mem_addr, 32'h0);
    chk("t5_data", mem_wdata, 32'hDDCC_BBAA);
    in_valid = 1'b0;
    tick();
    chk("t5_done", done, 1);
    chk("t5_wr_count", wr_count, 3);

    // start during DATA is ignored
    start = 1'b1; tick(); start = 1'b0;
    send(8'h01); send(8'h00);
    start = 1'b1; send(8'h11); start = 1'b0;
    send(8'h22); send(8'h33); send(8'h44);
    chk("t6_we", mem_we, 1);
    chk("t6_addr", mem_addr, 32'h0);
    chk("t6_data", mem_wdata, 32'h4433_2211);
    in_valid = 1'b0;
    tick();
    chk("t6_done", done, 1);
    chk("t6_wr_count", wr_count, 4);

    // Reset in the middle of the second word
    start = 1'b1; tick(); start = 1'b0;
    send(8'h02); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h55); send(8'h66);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("t7_ready", in_ready, 0);
    chk("t7_we", mem_we, 0);
    chk("t7_hold", cpu_hold, 1);
    chk("t7_done", done, 0);
    tick(); tick();
    chk("t7_wr_count", wr_count, 5);
    start = 1'b1; tick(); start = 1'b0;
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t7_new_we", mem_we, 1);
    chk("t7_new_addr", mem_addr, 32'h0);
    chk("t7_new_data", mem_wdata, 32'h0403_0201);
    in_valid = 1'b0;
    tick();
    chk("t7_new_done", done, 1);
    chk("t7_new_wr_count", wr_count, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
